rv32i_writeback_arbiter: RTL and testbench

Parametrised writeback stage that merges NUM_SRC result producers into the single register-file write port. Example producers are the ALU, the load unit and the CSR unit. Each source has a valid/ready handshake. Results are granted round-robin into a FIFO_DEPTH-entry write queue, which drains to the register file under a write/acknowledge handshake. A combinational hazard query reports whether a destination register still has a pending write, so decode can stall on it.

---
 rtl/rv32i_writeback_arbiter.sv | 109 ++++++++++
 tb/tb_rv32i_writeback_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_writeback_arbiter.sv
// rv32i_writeback_arbiter: round-robin merge of result producers into a queued register-file write port
module rv32i_writeback_arbiter #(
  parameter int WORD_SIZE  = 32,
  parameter int NUM_SRC    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_SRC-1:0]             i_src_valid,
  output logic [NUM_SRC-1:0]             o_src_ready,
  input  logic [NUM_SRC*WORD_SIZE-1:0]   i_src_data,
  input  logic [NUM_SRC*5-1:0]           i_src_addr,
  output logic                           o_register_write_en,
  output logic [WORD_SIZE-1:0]           o_register_write_data,
  output logic [4:0]                     o_register_write_addr,
  input  logic                           i_register_write_ack,
  input  logic [4:0]                     i_hazard_addr,
  output logic                           o_hazard_pending,
  output logic                           o_idle
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;

  logic [AW:0]           cnt_q, cnt_d;
  logic [AW-1:0]         rd_q, rd_d, wr_q, wr_d, off;
  logic [SW-1:0]         rr_q, rr_d, gidx;
  logic [WORD_SIZE-1:0]  data_q [FIFO_DEPTH];
  logic [WORD_SIZE-1:0]  data_d [FIFO_DEPTH];
  logic [4:0]            addr_q [FIFO_DEPTH];
  logic [4:0]            addr_d [FIFO_DEPTH];
  logic [NUM_SRC-1:0]    grant;
  logic [4:0]            in_addr;
  logic                  full, xfer, push, pop, found;
  int                    j;

  // First valid source at or after the round-robin pointer wins
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      j = int'(rr_q) + i;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (!found && i_src_valid[j]) begin
        found = 1'b1;
        gidx  = SW'(j);
        grant = NUM_SRC'(1) << j;
      end
    end
  end

  assign full                  = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign o_src_ready           = full ? '0 : grant;
  assign xfer                  = |o_src_ready;
  assign in_addr               = i_src_addr[gidx*5 +: 5];
  assign push                  = xfer && in_addr != 5'd0;
  assign o_register_write_en   = cnt_q != '0;
  assign pop                   = o_register_write_en && i_register_write_ack;
  assign o_register_write_data = data_q[rd_q];
  assign o_register_write_addr = addr_q[rd_q];
  assign o_idle                = cnt_q == '0;

  // Queue, pointer and arbitration next state; x0 results are accepted but never queued
  always_comb begin
    data_d = data_q;
    addr_d = addr_q;
    if (push) begin
      data_d[wr_q] = i_src_data[gidx*WORD_SIZE +: WORD_SIZE];
      addr_d[wr_q] = in_addr;
    end
    wr_d  = push ? wr_q + 1'b1 : wr_q;
    rd_d  = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    rr_d  = !xfer ? rr_q : gidx == SW'(NUM_SRC-1) ? '0 : gidx + 1'b1;
  end

  // Hazard: any occupied entry (head included, same-cycle push excluded) targeting the queried register
  always_comb begin
    o_hazard_pending = 1'b0;
    off = '0;
    for (int e = 0; e < FIFO_DEPTH; e++) begin
      off = AW'(e) - rd_q;
      if ({1'b0, off} < cnt_q && addr_q[e] == i_hazard_addr) o_hazard_pending = 1'b1;
    end
    o_hazard_pending = o_hazard_pending && i_hazard_addr != 5'd0;
  end

  // State registers; reset discards every queued write
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      rr_q  <= '0;
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        data_q[e] <= '0;
        addr_q[e] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      rr_q   <= rr_d;
      data_q <= data_d;
      addr_q <= addr_d;
    end
  end
endmodule

// File: tb/tb_rv32i_writeback_arbiter.sv
// tb_rv32i_writeback_arbiter: directed self-checking bench for the writeback arbiter
module tb_rv32i_writeback_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  src_valid = '0;
  logic [2:0]  src_ready;
  logic [95:0] src_data = '0;
  logic [14:0] src_addr = '0;
  logic        we;
  logic [31:0] wdata;
  logic [4:0]  waddr;
  logic        ack = 1'b0;
  logic [4:0]  haddr = '0;
  logic        hpend;
  logic        idle;
  int          tests = 0;
  int          fails = 0;

  rv32i_writeback_arbiter #(.WORD_SIZE(32), .NUM_SRC(3), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_src_valid(src_valid), .o_src_ready(src_ready),
    .i_src_data(src_data), .i_src_addr(src_addr),
    .o_register_write_en(we), .o_register_write_data(wdata), .o_register_write_addr(waddr),
    .i_register_write_ack(ack), .i_hazard_addr(haddr), .o_hazard_pending(hpend), .o_idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int k, input logic v, input logic [4:0] a, input logic [31:0] d);
    src_valid[k] = v;
    src_addr[k*5 +: 5] = a;
    src_data[k*32 +: 32] = d;
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_en", 32'(we), 32'd0);
    chk("rst_data", wdata, 32'd0);
    chk("rst_addr", 32'(waddr), 32'd0);
    chk("rst_ready", 32'(src_ready), 32'd0);
    chk("rst_hazard", 32'(hpend), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // single write to x5
    set_src(0, 1'b1, 5'd5, 32'hDEADBEEF);
    chk("single_ready", 32'(src_ready), 32'b001);
    tick();
    set_src(0, 1'b0, 5'd0, 32'h0);
    chk("single_en", 32'(we), 32'd1);
    chk("single_addr", 32'(waddr), 32'd5);
    chk("single_data", wdata, 32'hDEADBEEF);
    chk("single_busy", 32'(idle), 32'd0);
    haddr = 5'd5;
    #1;
    chk("single_hazard", 32'(hpend), 32'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    #1;
    chk("single_done_en", 32'(we), 32'd0);
    chk("single_done_idle", 32'(idle), 32'd1);
    chk("single_done_hazard", 32'(hpend), 32'd0);

    // round robin from pointer 0 with ack tied high
    reset_pulse();
    set_src(0, 1'b1, 5'd1, 32'h11);
    set_src(1, 1'b1, 5'd2, 32'h22);
    set_src(2, 1'b1, 5'd3, 32'h33);
    ack = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr_ready%0d", i), 32'(src_ready), 32'(1 << (i % 3)));
      if (i > 0) begin
        chk($sformatf("rr_en%0d", i), 32'(we), 32'd1);
        chk($sformatf("rr_addr%0d", i), 32'(waddr), 32'((i - 1) % 3 + 1));
        chk($sformatf("rr_data%0d", i), wdata, 32'(((i - 1) % 3 + 1) * 32'h11));
      end
      tick();
    end
    src_valid = '0;
    #1;
    chk("rr_last_addr", 32'(waddr), 32'd3);
    chk("rr_last_data", wdata, 32'h33);
    tick();
    chk("rr_idle", 32'(idle), 32'd1);
    ack = 1'b0;

    // backpressure: source 1 fills the queue with ack low
    for (int n = 1; n <= 4; n++) begin
      set_src(1, 1'b1, 5'(n), 32'h100 + 32'(n));
      chk($sformatf("bp_ready%0d", n), 32'(src_ready), 32'b010);
      tick();
    end
    set_src(1, 1'b1, 5'd5, 32'h105);
    chk("bp_full_ready", 32'(src_ready), 32'd0);
    chk("bp_full_head", 32'(waddr), 32'd1);
    ack = 1'b1;
    #1;
    chk("bp_full_pop_ready", 32'(src_ready), 32'd0);
    chk("bp_drain1", wdata, 32'h101);
    tick();
    chk("bp_drain2", wdata, 32'h102);
    chk("bp_x5_ready", 32'(src_ready), 32'b010);
    tick();
    set_src(1, 1'b1, 5'd6, 32'h106);
    chk("bp_drain3", wdata, 32'h103);
    chk("bp_x6_ready", 32'(src_ready), 32'b010);
    tick();
    set_src(1, 1'b0, 5'd0, 32'h0);
    chk("bp_drain4", wdata, 32'h104);
    tick();
    chk("bp_drain5", wdata, 32'h105);
    chk("bp_drain5_addr", 32'(waddr), 32'd5);
    tick();
    chk("bp_drain6", wdata, 32'h106);
    tick();
    chk("bp_idle", 32'(idle), 32'd1);
    ack = 1'b0;

    // x0 write from source 2 is accepted and dropped
    haddr = 5'd0;
    set_src(2, 1'b1, 5'd0, 32'h12345678);
    chk("x0_ready", 32'(src_ready), 32'b100);
    chk("x0_hazard", 32'(hpend), 32'd0);
    tick();
    set_src(2, 1'b0, 5'd0, 32'h0);
    chk("x0_en", 32'(we), 32'd0);
    chk("x0_idle", 32'(idle), 32'd1);

    // hazard tracking on x7 and x9
    set_src(0, 1'b1, 5'd7, 32'h77);
    tick();
    set_src(0, 1'b1, 5'd9, 32'h99);
    haddr = 5'd9;
    #1;
    chk("hz_push_not_yet", 32'(hpend), 32'd0);
    tick();
    set_src(0, 1'b0, 5'd0, 32'h0);
    chk("hz_q9", 32'(hpend), 32'd1);
    haddr = 5'd8;
    #1;
    chk("hz_q8", 32'(hpend), 32'd0);
    haddr = 5'd7;
    #1;
    chk("hz_q7_head", 32'(hpend), 32'd1);
    ack = 1'b1;
    #1;
    chk("hz_q7_popping", 32'(hpend), 32'd1);
    tick();
    haddr = 5'd9;
    #1;
    chk("hz_q9_head", 32'(hpend), 32'd1);
    haddr = 5'd7;
    #1;
    chk("hz_q7_gone", 32'(hpend), 32'd0);
    tick();
    haddr = 5'd9;
    #1;
    chk("hz_q9_gone", 32'(hpend), 32'd0);
    chk("hz_idle", 32'(idle), 32'd1);
    ack = 1'b0;

    // reset mid-operation with three entries queued
    for (int n = 10; n <= 12; n++) begin
      set_src(0, 1'b1, 5'(n), 32'(n));
      tick();
    end
    set_src(0, 1'b0, 5'd0, 32'h0);
    chk("mid_en_before", 32'(we), 32'd1);
    haddr = 5'd11;
    #1;
    chk("mid_hazard_before", 32'(hpend), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_en", 32'(we), 32'd0);
    chk("mid_rst_idle", 32'(idle), 32'd1);
    chk("mid_rst_hazard", 32'(hpend), 32'd0);
    rst_n = 1'b1;
    ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("mid_after_en%0d", c), 32'(we), 32'd0);
    end
    ack = 1'b0;
    set_src(0, 1'b1, 5'd4, 32'hCAFE);
    tick();
    set_src(0, 1'b0, 5'd0, 32'h0);
    chk("mid_new_en", 32'(we), 32'd1);
    chk("mid_new_data", wdata, 32'hCAFE);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
